bu_vector_loader: RTL and testbench
===================================

// Module: bu_vector_loader
// PURPOSE
// Front-end producer for the B.U dot-product unit. Accepts a serial stream of Q-format 16-bit words
// (M words of B, then M words of U) and packs them into the two 16*M-bit buses the unit reads.
// It pulses the unit's start (enable) line, waits for the unit's result, and forwards result plus
// error flag downstream on a valid/ready handshake. A timeout guards against a unit that never answers.
// PARAMETERS
// M        3   elements per vector; legal range 1..255
// TIMEOUT  64  max cycles in WAIT before aborting; legal range >=M+3
// PORTS
// clk        in   1     single clock, rising edge
// rst_n      in   1     asynchronous active-low reset
// in_data    in   16    stream word (B0..B(M-1), then U0..U(M-1))
// in_valid   in   1     in_data valid
// in_ready   out  1     loader can accept in_data
// b_vec      out  16*M  packed B to the unit, element k at [16*(M-k)-1 -:16]
// u_vec      out  16*M  packed U to the unit, same packing
// start      out  1     one-cycle pulse; drives the unit's enable
// res_data   in   16    unit result (h*B.U)
// res_err    in   1     unit error flag
// res_valid  in   1     one-cycle pulse: res_data/res_err valid
// out_data   out  16    forwarded result
// out_err    out  1     res_err, or 1 on timeout
// out_valid  out  1     out_data/out_err valid
// out_ready  in   1     downstream accepts
// busy       out  1     high in every state except LOAD_B with idx==0
// BEHAVIOUR
// - Reset (async, immediate): state=LOAD_B, idx=0, b_vec=u_vec=0, start=0, out_valid=0,
//   out_data=0, out_err=0, in_ready=1, busy=0. Reset mid-operation discards all partial data.
// - FSM: LOAD_B -> LOAD_U -> START -> WAIT -> OUT -> LOAD_B.
// - LOAD_B/LOAD_U: in_ready=1. A word transfers when in_valid&in_ready. Word idx is written to
//   slot [16*(M-idx)-1 -:16], so first-arriving word lands in the MSBs. The unit consumes MSB
//   first. idx increments per transfer and wraps to 0 after M-1 while advancing state.
//   No transfer means no change.
// - START: in_ready=0; start=1 for exactly this cycle. Timeout counter cleared. Next state WAIT.
// - WAIT: in_ready=0. b_vec/u_vec held stable until OUT is left.
//   - res_valid=1: capture out_data=res_data, out_err=res_err, go to OUT.
//   - Counter reaches TIMEOUT-1 without res_valid: out_data=16'h0000, out_err=1, go to OUT.
//   - res_valid in the same cycle as the timeout: result wins, out_err=res_err.
//   - res_valid outside WAIT is ignored.
// - OUT: out_valid=1 and out_data/out_err stable until out_valid&out_ready; then out_valid=0,
//   next state LOAD_B. in_ready=0 in OUT, so no overlap with the next load.
// - Latency: last U word accepted at cycle t -> start high at t+1; out_valid at the cycle after
//   res_valid; earliest new B word accepted the cycle after the out handshake.
// - start depends only on state (registered), never on inputs combinationally.
// TESTING
// - M=3; stream 0x0100,0x0200,0x0300,0x0400,0x0500,0x0600 back-to-back -> b_vec=0x010002000300,
//   u_vec=0x040005000600; start high exactly 1 cycle, the cycle after the 6th accept.
// - in_valid toggled 1/0 per cycle during load -> same packing, idx stalls on idle cycles,
//   no extra start.
// - Model answers 4 cycles after start with res_data=0x1234, res_err=0 -> out_valid=1,
//   out_data=0x1234, out_err=0; hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0.
// - No res_valid, TIMEOUT=64 -> out_valid 64 cycles after WAIT entry, out_data=0, out_err=1;
//   then a fresh load works.
// - res_valid coincident with timeout cycle, res_data=0x00FF, res_err=0 -> out_data=0x00FF,
//   out_err=0.
// - rst_n low for 1 cycle after 4 of 6 words -> all outputs at reset values at once;
//   the next 6 words load from slot 0.

Source files
------------

// File: rtl/bu_vector_loader.sv
// Packs a serial stream of M B-words then M U-words into the unit's operand buses.
// It pulses start, waits for the result (with a timeout), and forwards it on valid/ready.
module bu_vector_loader #(
    parameter int M       = 3,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [15:0]     in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [16*M-1:0] b_vec,
    output logic [16*M-1:0] u_vec,
    output logic            start,
    input  logic [15:0]     res_data,
    input  logic            res_err,
    input  logic            res_valid,
    output logic [15:0]     out_data,
    output logic            out_err,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy
);

    localparam int IW = (M > 1) ? $clog2(M) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_LOAD_B,
        S_LOAD_U,
        S_START,
        S_WAIT,
        S_OUT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_nxt;
    logic [CW-1:0] cnt;
    logic          xfer;
    logic          last_word;
    logic          timeout_hit;

    assign xfer        = in_valid & in_ready;
    assign last_word   = (idx == IW'(M - 1));
    assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        in_ready  = 1'b0;
        start     = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_LOAD_B, S_LOAD_U: begin
                in_ready = 1'b1;
                if (xfer) begin
                    if (last_word) begin
                        idx_nxt   = '0;
                        state_nxt = (state == S_LOAD_B) ? S_LOAD_U : S_START;
                    end else begin
                        idx_nxt = idx + IW'(1);
                    end
                end
            end
            S_START: begin
                start     = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (res_valid || timeout_hit)
                    state_nxt = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = S_LOAD_B;
            end
            default: state_nxt = S_LOAD_B;
        endcase
    end

    assign busy = !((state == S_LOAD_B) && (idx == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_LOAD_B;
            idx      <= '0;
            cnt      <= '0;
            b_vec    <= '0;
            u_vec    <= '0;
            out_data <= '0;
            out_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            // First-arriving word occupies the MSB slot; the unit walks MSB first.
            for (int k = 0; k < M; k++) begin
                if (xfer && idx == IW'(k)) begin
                    if (state == S_LOAD_B)
                        b_vec[16*(M-k)-1 -: 16] <= in_data;
                    else
                        u_vec[16*(M-k)-1 -: 16] <= in_data;
                end
            end
            if (state == S_START)
                cnt <= '0;
            else if (state == S_WAIT)
                cnt <= cnt + CW'(1);
            // A result arriving on the timeout cycle still takes priority.
            if (state == S_WAIT) begin
                if (res_valid) begin
                    out_data <= res_data;
                    out_err  <= res_err;
                end else if (timeout_hit) begin
                    out_data <= 16'h0000;
                    out_err  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bu_vector_loader.sv
// Directed bench for bu_vector_loader with M=3, TIMEOUT=64.
module tb_bu_vector_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] b_vec;
    logic [47:0] u_vec;
    logic        start;
    logic [15:0] res_data;
    logic        res_err;
    logic        res_valid;
    logic [15:0] out_data;
    logic        out_err;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int n_vec  = 0;
    int n_miss = 0;

    bu_vector_loader #(.M(3), .TIMEOUT(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .b_vec     (b_vec),
        .u_vec     (u_vec),
        .start     (start),
        .res_data  (res_data),
        .res_err   (res_err),
        .res_valid (res_valid),
        .out_data  (out_data),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Six words back to back; word j taken from ws[95-16*j -: 16].
    task automatic load6(input logic [95:0] ws);
        for (int i = 0; i < 6; i++) begin
            in_data  = ws[95-16*i -: 16];
            in_valid = 1'b1;
            tick();
            if (i < 5) chk("start_during_load", {63'd0, start}, 64'd0);
        end
        in_valid = 1'b0;
        in_data  = 16'h0000;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hs_out_valid", {63'd0, out_valid}, 64'd0);
        chk("hs_in_ready", {63'd0, in_ready}, 64'd1);
        chk("hs_busy", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        logic [95:0] tw;
        rst_n     = 1'b0;
        in_data   = 16'h0000;
        in_valid  = 1'b0;
        res_data  = 16'h0000;
        res_err   = 1'b0;
        res_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_start", {63'd0, start}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_b_vec", {16'd0, b_vec}, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Back-to-back load, then answer 4 cycles after start.
        load6(96'h0100_0200_0300_0400_0500_0600);
        chk("bb_start", {63'd0, start}, 64'd1);
        chk("bb_in_ready", {63'd0, in_ready}, 64'd0);
        chk("bb_b_vec", {16'd0, b_vec}, 64'h0000_0100_0200_0300);
        chk("bb_u_vec", {16'd0, u_vec}, 64'h0000_0400_0500_0600);
        tick();
        chk("bb_start_one_cycle", {63'd0, start}, 64'd0);
        repeat (3) tick();
        res_valid = 1'b1;
        res_data  = 16'h1234;
        res_err   = 1'b0;
        tick();
        res_valid = 1'b0;
        chk("res_out_valid", {63'd0, out_valid}, 64'd1);
        chk("res_out_data", {48'd0, out_data}, 64'h1234);
        chk("res_out_err", {63'd0, out_err}, 64'd0);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                res_valid = 1'b1;
                res_data  = 16'hBEEF;
                res_err   = 1'b1;
            end
            tick();
            res_valid = 1'b0;
            chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_out_data", {48'd0, out_data}, 64'h1234);
            chk("hold_out_err", {63'd0, out_err}, 64'd0);
            chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
            chk("hold_b_vec", {16'd0, b_vec}, 64'h0000_0100_0200_0300);
        end
        handshake();

        // Toggled in_valid with junk on idle cycles; then let it time out.
        tw = 96'h1111_2222_3333_4444_5555_6666;
        for (int i = 0; i <= 10; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = in_valid ? tw[95-16*(i/2) -: 16] : 16'hDEAD;
            tick();
            if (i < 10) chk("tog_start", {63'd0, start}, 64'd0);
        end
        in_valid = 1'b0;
        chk("tog_start_end", {63'd0, start}, 64'd1);
        chk("tog_b_vec", {16'd0, b_vec}, 64'h0000_1111_2222_3333);
        chk("tog_u_vec", {16'd0, u_vec}, 64'h0000_4444_5555_6666);
        for (int k = 1; k <= 65; k++) begin
            tick();
            if (k == 64) chk("to_not_yet", {63'd0, out_valid}, 64'd0);
        end
        chk("to_out_valid", {63'd0, out_valid}, 64'd1);
        chk("to_out_data", {48'd0, out_data}, 64'h0000);
        chk("to_out_err", {63'd0, out_err}, 64'd1);
        handshake();

        // Fresh load; result lands exactly on the timeout cycle.
        load6(96'hA001_A002_A003_B001_B002_B003);
        chk("co_start", {63'd0, start}, 64'd1);
        chk("co_b_vec", {16'd0, b_vec}, 64'h0000_A001_A002_A003);
        chk("co_u_vec", {16'd0, u_vec}, 64'h0000_B001_B002_B003);
        repeat (64) tick();
        chk("co_pre_out_valid", {63'd0, out_valid}, 64'd0);
        res_valid = 1'b1;
        res_data  = 16'h00FF;
        res_err   = 1'b0;
        tick();
        res_valid = 1'b0;
        chk("co_out_valid", {63'd0, out_valid}, 64'd1);
        chk("co_out_data", {48'd0, out_data}, 64'h00FF);
        chk("co_out_err", {63'd0, out_err}, 64'd0);
        handshake();

        // Reset after 4 of 6 words, then reload from slot 0.
        tw = 96'h0A0A_0B0B_0C0C_0D0D_0E0E_0F0F;
        for (int i = 0; i < 4; i++) begin
            in_data  = tw[95-16*i -: 16];
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        chk("mid_busy", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mrst_b_vec", {16'd0, b_vec}, 64'd0);
        chk("mrst_u_vec", {16'd0, u_vec}, 64'd0);
        chk("mrst_busy", {63'd0, busy}, 64'd0);
        chk("mrst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("mrst_out_data", {48'd0, out_data}, 64'd0);
        chk("mrst_out_err", {63'd0, out_err}, 64'd0);
        chk("mrst_start", {63'd0, start}, 64'd0);
        tick();
        rst_n = 1'b1;
        load6(96'h1010_2020_3030_4040_5050_6060);
        chk("rl_start", {63'd0, start}, 64'd1);
        chk("rl_b_vec", {16'd0, b_vec}, 64'h0000_1010_2020_3030);
        chk("rl_u_vec", {16'd0, u_vec}, 64'h0000_4040_5050_6060);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
